// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared constants and types for the FIFO read-side controller.
//   FIFO_WIDTH    - default data word width, matches the FIFO instance
//   FIFO_RD_BURST - default words per burst for m_last generation
//   rd_occ_t      - occupancy of the 2-entry elastic buffer (value == word count)
package fifo_rd_pkg;

    localparam int FIFO_WIDTH    = 16;
    localparam int FIFO_RD_BURST = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } rd_occ_t;

endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry elastic buffer that absorbs the FIFO's one-cycle read
// latency. Entry "head" always holds the oldest word.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   push        - write push_data this cycle
//   push_data   - word to write
//   pop         - head word consumed this cycle
//   head_data   - oldest buffered word
//   occ         - occupancy (EMPTY / ONE / FULL2)
module skid_buf2
    import fifo_rd_pkg::*;
#(
    parameter int width = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head_data,
    output rd_occ_t          occ
);

    rd_occ_t          occ_q, occ_d;
    logic [width-1:0] head_q, head_d;
    logic [width-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            EMPTY: begin
                // A pop while empty is never qualified by the stream, so it is ignored.
                if (push) begin
                    head_d = push_data;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d = push_data;
                        occ_d  = FULL2;
                    end
                    2'b01: occ_d = EMPTY;
                    // Head leaves and the incoming word replaces it directly.
                    2'b11: head_d = push_data;
                    default: ;
                endcase
            end
            FULL2: begin
                // The read-issue logic never pushes here without a pop.
                if (pop) begin
                    head_d = tail_q;
                    if (push) tail_d = push_data;
                    else      occ_d  = ONE;
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head_data = head_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the synchronous FIFO. Drains words via
// fifo_re / fifo_empty / fifo_data and presents them on a valid/ready stream,
// sustaining one word per cycle under continuous m_ready.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset (shared with the FIFO)
//   fifo_empty  - FIFO empty flag
//   fifo_data   - FIFO data_out, valid the cycle after fifo_re
//   fifo_re     - FIFO read strobe
//   m_data      - stream data
//   m_valid     - stream word valid
//   m_ready     - consumer ready
//   m_last      - last word of a burst (only when FIFO_RD_LAST_EN is defined)
// Build option: define FIFO_RD_LAST_EN to add m_last and the burst counter;
// otherwise the burst parameter has no effect.
module fifo_reader
    import fifo_rd_pkg::*;
#(
    parameter int width = FIFO_WIDTH,
    parameter int burst = FIFO_RD_BURST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_data,
    output logic             fifo_re,
    output logic [width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
`ifdef FIFO_RD_LAST_EN
    ,
    output logic             m_last
`endif
);

    rd_occ_t    occ;
    logic       pend_q, pend_d;
    logic       pop;
    logic [2:0] fill_next;

    skid_buf2 #(
        .width(width)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (pend_q),
        .push_data(fifo_data),
        .pop      (pop),
        .head_data(m_data),
        .occ      (occ)
    );

    assign m_valid = (occ != EMPTY);
    assign pop     = m_valid && m_ready;

    always_comb begin
        // Words already buffered plus the one in flight, after this cycle's pop.
        fill_next = {1'b0, occ} + 3'(pend_q) - 3'(pop);
        // Gated by rst so the strobe stays low while both sides are held in reset.
        fifo_re   = !rst && !fifo_empty && (fill_next < 3'd2);
        pend_d    = fifo_re;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= 1'b0;
        else     pend_q <= pend_d;
    end

`ifdef FIFO_RD_LAST_EN
    localparam int BCNT_W = (burst > 1) ? $clog2(burst) : 1;
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(burst - 1);

    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    always_comb begin
        bcnt_d = bcnt_q;
        if (pop) bcnt_d = (bcnt_q == BCNT_MAX) ? '0 : bcnt_q + BCNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bcnt_q <= '0;
        else     bcnt_q <= bcnt_d;
    end

    assign m_last = m_valid && (bcnt_q == BCNT_MAX);
`else
    logic unused_burst;
    assign unused_burst = (burst != 0);
`endif

endmodule
